bnn_dot_unit: RTL and testbench

- Pipelined, parametrised binarised dot-product unit for the execute stage; successor to the single-word XNOR-popcount BNN operation.
- Streams operand word pairs over a valid/ready handshake.
- Each beat: XNOR, then popcount; results accumulate across a multi-word vector.
- Emits one of: raw popcount, accumulated popcount, signed ±1 dot product, or thresholded binary activation.

---
 rtl/bnn_dot_unit.sv | 172 +++++++++++++++++
 tb/tb_bnn_dot_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_dot_unit.sv
// rtl/bnn_dot_unit.sv - pipelined binarised XNOR-popcount dot-product unit
// S1 registers the popcount of each beat; S2 accumulates and produces results.
module bnn_dot_unit #(
    parameter int XLEN  = 32,
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [1:0]       op_mode,
    input  logic             op_last,
    input  logic [ACC_W-1:0] thresh,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             sat
);
    localparam int PC_W = $clog2(XLEN) + 1;
    localparam int SUM_W = ACC_W + 1;

    localparam logic [1:0] MODE_POP  = 2'b00;
    localparam logic [1:0] MODE_ACC  = 2'b01;
    localparam logic [1:0] MODE_SDOT = 2'b10;
    localparam logic [1:0] MODE_THR  = 2'b11;

    logic             vec_active_q, vec_active_d;
    logic [1:0]       vmode_q, vmode_d;
    logic             s1_valid_q, s1_valid_d;
    logic [PC_W-1:0]  s1_pc_q, s1_pc_d;
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s1_last_q, s1_last_d;
    logic [ACC_W-1:0] s1_thresh_q, s1_thresh_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic             sat_q, sat_d;

    logic             stall, accept, consume;
    logic [XLEN-1:0]  match_w;
    logic [PC_W-1:0]  pc_w;
    logic [1:0]       beat_mode;
    logic             beat_last;
    logic [SUM_W-1:0] sum_ext;
    logic [ACC_W-1:0] sum_sat, dot_w;
    logic             cnt_max, flag_nxt, thr_hit;
    logic [CNT_W-1:0] cnt_nxt;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = reset_n & ~stall;
    assign accept    = in_valid & in_ready & ~abort;
    assign consume   = s1_valid_q & ~stall & ~abort;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat       = sat_q;

    // Mode is captured on the first beat; POP beats each close their own vector.
    assign beat_mode = vec_active_q ? vmode_q : op_mode;
    assign beat_last = (beat_mode == MODE_POP) | op_last;

    always_comb begin
        match_w = ~(op_a ^ op_b);
        pc_w    = '0;
        for (int i = 0; i < XLEN; i++) begin
            pc_w = pc_w + PC_W'(match_w[i]);
        end
    end

    assign sum_ext  = {1'b0, acc_q} + SUM_W'(s1_pc_q);
    assign sum_sat  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    assign cnt_max  = &cnt_q;
    assign cnt_nxt  = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
    assign flag_nxt = flag_q | sum_ext[ACC_W] | cnt_max;
    // 2*sum - XLEN*n only matters modulo 2^ACC_W, so it is formed at ACC_W bits.
    assign dot_w    = {sum_sat[ACC_W-2:0], 1'b0} - ACC_W'(XLEN) * ACC_W'(cnt_nxt);
    assign thr_hit  = sum_sat >= s1_thresh_q;

    always_comb begin
        vec_active_d = vec_active_q;
        vmode_d      = vmode_q;
        s1_valid_d   = s1_valid_q;
        s1_pc_d      = s1_pc_q;
        s1_mode_d    = s1_mode_q;
        s1_last_d    = s1_last_q;
        s1_thresh_d  = s1_thresh_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flag_d       = flag_q;
        out_valid_d  = out_valid_q;
        result_d     = result_q;
        sat_d        = sat_q;
        if (!stall) begin
            s1_valid_d  = accept;
            out_valid_d = 1'b0;
            if (accept) begin
                s1_pc_d      = pc_w;
                s1_mode_d    = beat_mode;
                s1_last_d    = beat_last;
                s1_thresh_d  = thresh;
                vec_active_d = ~beat_last;
                vmode_d      = beat_mode;
            end
            if (consume) begin
                if (s1_mode_q == MODE_POP) begin
                    out_valid_d = 1'b1;
                    result_d    = ACC_W'(s1_pc_q);
                    sat_d       = 1'b0;
                end else if (s1_last_q) begin
                    out_valid_d = 1'b1;
                    sat_d       = flag_nxt;
                    acc_d       = '0;
                    cnt_d       = '0;
                    flag_d      = 1'b0;
                    case (s1_mode_q)
                        MODE_SDOT: result_d = dot_w;
                        MODE_THR:  result_d = {{(ACC_W-1){1'b0}}, thr_hit};
                        default:   result_d = sum_sat;
                    endcase
                end else begin
                    acc_d  = sum_sat;
                    cnt_d  = cnt_nxt;
                    flag_d = flag_nxt;
                end
            end
        end
        if (abort) begin
            vec_active_d = 1'b0;
            s1_valid_d   = 1'b0;
            acc_d        = '0;
            cnt_d        = '0;
            flag_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_active_q <= 1'b0;
            vmode_q      <= MODE_POP;
            s1_valid_q   <= 1'b0;
            s1_pc_q      <= '0;
            s1_mode_q    <= MODE_POP;
            s1_last_q    <= 1'b0;
            s1_thresh_q  <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            flag_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            sat_q        <= 1'b0;
        end else begin
            vec_active_q <= vec_active_d;
            vmode_q      <= vmode_d;
            s1_valid_q   <= s1_valid_d;
            s1_pc_q      <= s1_pc_d;
            s1_mode_q    <= s1_mode_d;
            s1_last_q    <= s1_last_d;
            s1_thresh_q  <= s1_thresh_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            flag_q       <= flag_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            sat_q        <= sat_d;
        end
    end
endmodule

// File: tb/tb_bnn_dot_unit.sv
// tb/tb_bnn_dot_unit.sv - scoreboard bench for bnn_dot_unit at ACC_W=16 and ACC_W=6
// Both instances see identical stimulus; the reference model works per vector.
module tb_bnn_dot_unit;
    localparam logic [1:0] M_POP = 2'd0, M_ACC = 2'd1, M_SDOT = 2'd2, M_THR = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, op_last = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [31:0] op_a = '0, op_b = '0;
    logic [1:0]  op_mode = '0;
    logic [15:0] thresh = '0;
    logic        in_ready, out_valid, sat, in_ready1, out_valid1, sat1;
    logic [15:0] result;
    logic [5:0]  result1;

    always #5 clk = ~clk;

    bnn_dot_unit #(.XLEN(32), .ACC_W(16), .CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_mode(op_mode), .op_last(op_last),
        .thresh(thresh), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat(sat)
    );

    bnn_dot_unit #(.XLEN(32), .ACC_W(6), .CNT_W(8)) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
        .op_a(op_a), .op_b(op_b), .op_mode(op_mode), .op_last(op_last),
        .thresh(thresh[5:0]), .abort(abort), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .sat(sat1)
    );

    typedef struct {
        logic [15:0] r0;
        logic        s0;
        logic [5:0]  r1;
        logic        s1;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    bit         m_active = 0;
    logic [1:0] m_mode = M_POP;
    int         m_sum = 0, m_nb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic void model_clear();
        m_active = 0;
        m_sum    = 0;
        m_nb     = 0;
    endfunction

    // Vector result from the whole-vector totals, clamped to the result width.
    function automatic void exp_vec(input int w, input logic [15:0] thr,
                                    output logic [15:0] r, output logic s);
        longint mx, sm, n;
        mx = (longint'(1) << w) - 1;
        sm = (m_sum > mx) ? mx : longint'(m_sum);
        n  = (m_nb > 255) ? 255 : longint'(m_nb);
        s  = (m_sum > mx) || (m_nb > 255);
        case (m_mode)
            M_ACC:   r = 16'(sm);
            M_SDOT:  r = 16'((2 * sm - 32 * n) & mx);
            default: r = {15'd0, sm >= longint'(thr & 16'(mx))};
        endcase
    endfunction

    function automatic void model_accept(input logic [31:0] a, b, input logic [1:0] md,
                                         input logic lst, input logic [15:0] thr);
        int          pc;
        logic [1:0]  md_eff;
        logic [15:0] r;
        logic        s;
        exp_t        e;
        pc     = $countones(~(a ^ b));
        md_eff = m_active ? m_mode : md;
        if (md_eff == M_POP) begin
            e.r0 = 16'(pc); e.s0 = 1'b0; e.r1 = 6'(pc); e.s1 = 1'b0;
            sbq.push_back(e);
            model_clear();
        end else begin
            m_mode   = md_eff;
            m_active = 1;
            m_sum    = m_sum + pc;
            m_nb     = m_nb + 1;
            if (lst) begin
                exp_vec(16, thr, r, s); e.r0 = r;      e.s0 = s;
                exp_vec(6,  thr, r, s); e.r1 = r[5:0]; e.s1 = s;
                sbq.push_back(e);
                model_clear();
            end
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] a, b, input logic [1:0] md,
                        input logic lst, input logic [15:0] thr);
        bit got;
        int guard;
        got = 0; guard = 0;
        op_a = a; op_b = b; op_mode = md; op_last = lst; thresh = thr; in_valid = 1'b1;
        while (!got && guard < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(got), 64'd1);
        if (got) model_accept(a, b, md, lst, thr);
    endtask

    // Let S1 drain so only a partial vector can be discarded, then abort one cycle.
    task automatic do_abort(input bit with_beat);
        bit got;
        int guard;
        got = 0; guard = 0;
        while (!got && guard < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("abort_drain", 64'(got), 64'd1);
        op_a = $urandom; op_b = $urandom; op_mode = 2'($urandom); op_last = 1'($urandom);
        in_valid = with_beat;
        abort    = 1'b1;
        idle(1);
        abort    = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t        e;
        bit          pstall;
        logic [15:0] presult;
        logic        psat;
        pstall = 0; presult = '0; psat = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pstall = 0;
            end else begin
                if (pstall) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_result", 64'(result), 64'(presult));
                    chk("hold_sat", 64'(sat), 64'(psat));
                end
                if (out_valid && !out_ready) chk("stall_in_ready", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("spurious_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", 64'(result), 64'(e.r0));
                        chk("sat", 64'(sat), 64'(e.s0));
                        chk("valid_w6", 64'(out_valid1), 64'd1);
                        chk("result_w6", 64'(result1), 64'(e.r1));
                        chk("sat_w6", 64'(sat1), 64'(e.s1));
                    end
                end
                pstall  = out_valid && !out_ready;
                presult = result;
                psat    = sat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t0;
        idle(3);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_sat", 64'(sat), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        idle(1);

        send(32'hFFFF0000, 32'hFFFFFFFF, M_POP, 1'b0, 16'd0);
        @(negedge clk);
        chk("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_two", 64'(out_valid), 64'd1);
        idle(1);
        send(32'h0, 32'h0, M_POP, 1'b0, 16'd0);
        send(32'h0, 32'hFFFFFFFF, M_POP, 1'b1, 16'd0);

        send(32'h0, 32'h0,        M_ACC, 1'b0, 16'd0);
        send(32'h0, 32'h0000FFFF, M_POP, 1'b0, 16'd0);
        send(32'h0, 32'hFFFFFFFF, M_SDOT, 1'b1, 16'd0);

        send(32'h0, 32'h00000FFF, M_SDOT, 1'b0, 16'd0);
        send(32'h0, 32'h00FFFFFF, M_ACC,  1'b1, 16'd0);
        send(32'h0, 32'h00000FFF, M_THR,  1'b0, 16'd0);
        send(32'h0, 32'h00FFFFFF, M_THR,  1'b1, 16'd28);
        send(32'h0, 32'h00000FFF, M_THR,  1'b0, 16'd0);
        send(32'h0, 32'h00FFFFFF, M_THR,  1'b1, 16'd29);
        idle(2);

        fork
            begin
                rdy_mode = 2;
                repeat (7) @(posedge clk);
                rdy_mode = 0;
            end
            for (int i = 0; i < 10; i++) send($urandom, $urandom, M_POP, 1'b0, 16'd0);
        join
        idle(3);
        t0 = cyc;
        for (int i = 0; i < 10; i++) send($urandom, $urandom, M_POP, 1'b0, 16'd0);
        chk("throughput_cycles", 64'(cyc - t0), 64'd10);

        for (int i = 0; i < 3; i++) send(32'h0, 32'h0, M_ACC, (i == 2), 16'd0);
        send(32'h0, 32'hFFFFFFE0, M_ACC, 1'b1, 16'd0);

        send(32'h0, 32'h0, M_ACC, 1'b0, 16'd0);
        send(32'h0, 32'h0, M_ACC, 1'b0, 16'd0);
        do_abort(1'b1);
        send(32'h0, 32'hFFFFFFE0, M_ACC, 1'b1, 16'd0);
        idle(3);

        rdy_mode = 2;
        idle(1);
        send(32'h0, 32'h0, M_POP, 1'b0, 16'd0);
        send(32'h0, 32'h0, M_ACC, 1'b0, 16'd0);
        idle(2);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_result", 64'(result), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        chk("async_rst_sat_w6", 64'(sat1), 64'd0);
        sbq.delete();
        model_clear();
        rdy_mode = 0;
        idle(2);
        reset_n = 1'b1;
        idle(1);
        send(32'h0, 32'hFFFFFFE0, M_ACC, 1'b1, 16'd0);
        send(32'h0, 32'h0, M_SDOT, 1'b1, 16'd0);

        rdy_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                do_abort(1'($urandom));
            end else begin
                send($urandom, $urandom, 2'($urandom), ($urandom_range(0, 3) == 0),
                     16'($urandom_range(0, 200)));
                if ($urandom_range(0, 7) == 0) idle(1);
            end
        end

        rdy_mode = 0;
        idle(10);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
